// File: rtl/array_feed_ctrl.sv
// Read-address sequencer that feeds A/B operand buffers into a systolic array, tile by tile.
// Optional macro FEED_SKEW_EN staggers row/column valids and lengthens DRAIN to cover the skew.
module array_feed_ctrl #(
   parameter int BUFFER_ADDRESS_WIDTH = 10,
   parameter int ARRAY_HEIGHT         = 4,
   parameter int ARRAY_WIDTH          = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start_i,
   input  logic                            array_start,
   input  logic [15:0]                     m,
   input  logic [15:0]                     n,
   input  logic [15:0]                     p,
   input  logic [15:0]                     a_wr_count,
   input  logic [15:0]                     b_wr_count,
   output logic                            a_rd_en,
   output logic                            b_rd_en,
   output logic [BUFFER_ADDRESS_WIDTH-1:0] a_rd_addr,
   output logic [BUFFER_ADDRESS_WIDTH-1:0] b_rd_addr,
   output logic                            feed_valid,
   output logic [ARRAY_HEIGHT-1:0]         row_valid,
   output logic [ARRAY_WIDTH-1:0]          col_valid,
   output logic                            feed_last,
   output logic                            data_done,
   output logic                            busy
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

   localparam int SKEW_MAX = ((ARRAY_HEIGHT > ARRAY_WIDTH) ? ARRAY_HEIGHT : ARRAY_WIDTH) - 1;
`ifdef FEED_SKEW_EN
   localparam int DRAIN_LEN = ARRAY_HEIGHT + ARRAY_WIDTH - 1 + SKEW_MAX;
`else
   localparam int DRAIN_LEN = ARRAY_HEIGHT + ARRAY_WIDTH - 1;
`endif
   localparam int          DW         = $clog2(DRAIN_LEN + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);
   localparam logic [31:0] H32        = 32'(ARRAY_HEIGHT);
   localparam logic [31:0] W32        = 32'(ARRAY_WIDTH);

   state_e         state_q, state_d;
   logic [15:0]    k_q, k_d;
   logic [31:0]    a_base_q, a_base_d, b_base_q, b_base_d;
   logic [31:0]    row_off_q, row_off_d, col_off_q, col_off_d;
   logic [DW-1:0]  drain_q, drain_d;
   logic           fv_q, fv_d, last_q, last_d;

   logic [31:0]    a_idx, b_idx;
   logic           can_rd, last_k, last_row, last_col, rd_en;

   // Tile offsets track rt*ARRAY_HEIGHT / ct*ARRAY_WIDTH so the last-tile test needs no divider.
   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      a_base_d  = a_base_q;
      b_base_d  = b_base_q;
      row_off_d = row_off_q;
      col_off_d = col_off_q;
      drain_d   = drain_q;
      fv_d      = 1'b0;
      last_d    = 1'b0;
      rd_en     = 1'b0;
      a_idx     = a_base_q + 32'(k_q);
      b_idx     = b_base_q + 32'(k_q);
      can_rd    = (a_idx < 32'(a_wr_count)) && (b_idx < 32'(b_wr_count));
      last_k    = (k_q == n - 16'd1);
      last_row  = (row_off_q + H32) >= 32'(m);
      last_col  = (col_off_q + W32) >= 32'(p);

      unique case (state_q)
         IDLE: begin
            if (array_start) begin
               if (m == 16'd0 || n == 16'd0 || p == 16'd0) state_d = DONE;
               else                                        state_d = FEED;
            end
         end
         FEED: begin
            if (can_rd) begin
               rd_en  = 1'b1;
               fv_d   = 1'b1;
               last_d = last_k;
               if (last_k) begin
                  k_d     = '0;
                  drain_d = '0;
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + 16'd1;
               end
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               drain_d = '0;
               if (last_col) begin
                  col_off_d = '0;
                  b_base_d  = '0;
                  if (last_row) begin
                     row_off_d = '0;
                     a_base_d  = '0;
                     state_d   = DONE;
                  end else begin
                     row_off_d = row_off_q + H32;
                     a_base_d  = a_base_q + 32'(n);
                     state_d   = FEED;
                  end
               end else begin
                  col_off_d = col_off_q + W32;
                  b_base_d  = b_base_q + 32'(n);
                  state_d   = FEED;
               end
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (start_i) begin
         state_d   = IDLE;
         k_d       = '0;
         a_base_d  = '0;
         b_base_d  = '0;
         row_off_d = '0;
         col_off_d = '0;
         drain_d   = '0;
         fv_d      = 1'b0;
         last_d    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         a_base_q  <= '0;
         b_base_q  <= '0;
         row_off_q <= '0;
         col_off_q <= '0;
         drain_q   <= '0;
         fv_q      <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         a_base_q  <= a_base_d;
         b_base_q  <= b_base_d;
         row_off_q <= row_off_d;
         col_off_q <= col_off_d;
         drain_q   <= drain_d;
         fv_q      <= fv_d;
         last_q    <= last_d;
      end
   end

   assign a_rd_en    = rd_en;
   assign b_rd_en    = rd_en;
   assign a_rd_addr  = a_idx[BUFFER_ADDRESS_WIDTH-1:0];
   assign b_rd_addr  = b_idx[BUFFER_ADDRESS_WIDTH-1:0];
   assign feed_valid = fv_q;
   assign feed_last  = last_q;
   assign data_done  = (state_q == DONE);
   assign busy       = (state_q != IDLE);

`ifdef FEED_SKEW_EN
   localparam int SKEW_W = (SKEW_MAX > 0) ? SKEW_MAX : 1;

   logic [SKEW_W-1:0] skew_q, skew_d;
   logic [SKEW_W:0]   taps;

   // skew_q[i] holds feed_valid delayed by i+1 cycles.
   always_comb begin
      skew_d[0] = fv_q;
      for (int i = 1; i < SKEW_W; i++) skew_d[i] = skew_q[i-1];
      if (start_i) skew_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) skew_q <= '0;
      else          skew_q <= skew_d;
   end

   assign taps = {skew_q, fv_q};

   for (genvar gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_row
      assign row_valid[gi] = taps[gi];
   end
   for (genvar gj = 0; gj < ARRAY_WIDTH; gj++) begin : g_col
      assign col_valid[gj] = taps[gj];
   end
`else
   assign row_valid = {ARRAY_HEIGHT{fv_q}};
   assign col_valid = {ARRAY_WIDTH{fv_q}};
`endif

endmodule
